// File: rtl/dpram_arb_pkg.sv
// Shared constants and types for the dual-port RAM port arbiter.
// Holds the parameter defaults, the FSM state type and the per-port owner tag.
package dpram_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int AW_DEF    = 6;
  localparam int DW_DEF    = 8;

  // The owner index is wide enough for the largest legal requester count (8).
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } owner_t;

endpackage

// File: rtl/dpram_port_arbiter_if.sv
// Requester-side bus of the dual-port RAM arbiter: packed per-requester request and response lanes.
// The requesters drive it through the master modport and the arbiter serves it through the slave modport.
interface dpram_port_arbiter_if
  import dpram_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_wr;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [N_REQ*DW-1:0] rsp_data;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/dpram_rr_pick2.sv
// Combinational dual round-robin picker: starting at ptr, it grants the first
// valid requester as pick 0 and the second valid requester as pick 1.
module dpram_rr_pick2 #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt0,
  output logic [N-1:0]         gnt1,
  output logic                 any0,
  output logic                 any1,
  output logic [$clog2(N)-1:0] idx0,
  output logic [$clog2(N)-1:0] idx1
);

  localparam int IW = $clog2(N);

  always_comb begin
    int j;
    // NOTE: every output gets a default before the loop so that no path leaves it unassigned; otherwise a latch would be inferred.
    gnt0 = '0;
    gnt1 = '0;
    any0 = 1'b0;
    any1 = 1'b0;
    idx0 = '0;
    idx1 = '0;
    j    = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (valid[j]) begin
        if (!any0) begin
          any0    = 1'b1;
          idx0    = IW'(j);
          gnt0[j] = 1'b1;
        end else if (!any1) begin
          any1    = 1'b1;
          idx1    = IW'(j);
          gnt1[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares the two ports of a registered-output dual-port RAM between N_REQ requesters.
// Define DPRAM_ARB_INIT_EN to zero-fill the RAM after reset and expose init_done.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  dpram_port_arbiter_if.slave req_if,
  output logic                ram_en,
  output logic                ram_wr0,
  output logic                ram_wr1,
  output logic [AW-1:0]       ram_add0,
  output logic [AW-1:0]       ram_add1,
  output logic [DW-1:0]       ram_data0_in,
  output logic [DW-1:0]       ram_data1_in,
  input  logic [DW-1:0]       ram_data0_out,
  input  logic [DW-1:0]       ram_data1_out
`ifdef DPRAM_ARB_INIT_EN
  ,
  output logic                init_done
`endif
);

  localparam int IW = $clog2(N_REQ);

  state_e        state_q, state_d;
  logic          en_q, en_d;
  logic [IW-1:0] ptr_q, ptr_d;
  owner_t        tag0_q, tag0_d;
  owner_t        tag1_q, tag1_d;
`ifdef DPRAM_ARB_INIT_EN
  logic [AW-2:0] cnt_q, cnt_d;
  logic          init_done_q, init_done_d;
`endif

  logic [N_REQ-1:0] gnt0, gnt1;
  logic             any0, any1;
  logic [IW-1:0]    idx0, idx1;
  logic             run, use0, use1, wr0, wr1, collide;
  logic [AW-1:0]    addr0, addr1;
  logic [DW-1:0]    wdata0, wdata1;

  dpram_rr_pick2 #(.N(N_REQ)) u_pick (
    .valid (req_if.req_valid),
    .ptr   (ptr_q),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .any0  (any0),
    .any1  (any1),
    .idx0  (idx0),
    .idx1  (idx1)
  );

  // Two writes to one address cannot share a cycle; the port-1 requester retries.
  always_comb begin
    wr0     = req_if.req_wr[idx0];
    wr1     = req_if.req_wr[idx1];
    addr0   = req_if.req_addr[idx0*AW +: AW];
    addr1   = req_if.req_addr[idx1*AW +: AW];
    wdata0  = req_if.req_wdata[idx0*DW +: DW];
    wdata1  = req_if.req_wdata[idx1*DW +: DW];
    run     = en_q && (state_q == ST_RUN);
    collide = any0 && any1 && wr0 && wr1 && (addr0 == addr1);
    use0    = run && any0;
    use1    = run && any1 && !collide;
    req_if.req_ready = (use0 ? gnt0 : '0) | (use1 ? gnt1 : '0);
  end

  always_comb begin
    ram_en       = en_q;
    ram_wr0      = 1'b1;
    ram_wr1      = 1'b1;
    ram_add0     = '0;
    ram_add1     = '0;
    ram_data0_in = '0;
    ram_data1_in = '0;
    if (use0) begin
      ram_wr0      = !wr0;
      ram_add0     = addr0;
      ram_data0_in = wr0 ? wdata0 : '0;
    end
    if (use1) begin
      ram_wr1      = !wr1;
      ram_add1     = addr1;
      ram_data1_in = wr1 ? wdata1 : '0;
    end
`ifdef DPRAM_ARB_INIT_EN
    if (en_q && (state_q == ST_INIT)) begin
      ram_wr0  = 1'b0;
      ram_wr1  = 1'b0;
      ram_add0 = {cnt_q, 1'b0};
      ram_add1 = {cnt_q, 1'b1};
    end
    init_done = init_done_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    en_d    = 1'b1;
    ptr_d   = ptr_q;
    if (use1) begin
      ptr_d = (idx1 == IW'(N_REQ - 1)) ? '0 : idx1 + 1'b1;
    end else if (use0) begin
      ptr_d = (idx0 == IW'(N_REQ - 1)) ? '0 : idx0 + 1'b1;
    end
    tag0_d = '{valid: use0 && !wr0, idx: IDX_W'(idx0)};
    tag1_d = '{valid: use1 && !wr1, idx: IDX_W'(idx1)};
`ifdef DPRAM_ARB_INIT_EN
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    if (en_q && (state_q == ST_INIT)) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef DPRAM_ARB_INIT_EN
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
`else
      state_q     <= ST_RUN;
`endif
      en_q        <= 1'b0;
      ptr_q       <= '0;
      tag0_q      <= '0;
      tag1_q      <= '0;
    end else begin
`ifdef DPRAM_ARB_INIT_EN
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
`endif
      state_q     <= state_d;
      en_q        <= en_d;
      ptr_q       <= ptr_d;
      tag0_q      <= tag0_d;
      tag1_q      <= tag1_d;
    end
  end

  // Read data arrives one cycle after accept, matching the registered owner tags.
  always_comb begin
    logic hit0, hit1;
    hit0 = 1'b0;
    hit1 = 1'b0;
    req_if.rsp_valid = '0;
    req_if.rsp_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      hit0 = tag0_q.valid && (tag0_q.idx == IDX_W'(i));
      hit1 = tag1_q.valid && (tag1_q.idx == IDX_W'(i));
      req_if.rsp_valid[i] = hit0 || hit1;
      req_if.rsp_data[i*DW +: DW] = hit0 ? ram_data0_out : (hit1 ? ram_data1_out : '0);
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural 64x8 read-first dual-port RAM.
// Expected values are hand-computed from the round-robin order and the one-cycle read latency.
module tb_dpram_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic       ram_en, ram_wr0, ram_wr1;
  logic [5:0] ram_add0, ram_add1;
  logic [7:0] ram_data0_in, ram_data1_in;
  logic [7:0] ram_data0_out, ram_data1_out;
`ifdef DPRAM_ARB_INIT_EN
  logic       init_done;
`endif

  int n_checks = 0;
  int n_errors = 0;

  dpram_port_arbiter_if #(.N_REQ(4), .AW(6), .DW(8)) bus ();

  dpram_port_arbiter #(.N_REQ(4), .AW(6), .DW(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_if        (bus.slave),
    .ram_en        (ram_en),
    .ram_wr0       (ram_wr0),
    .ram_wr1       (ram_wr1),
    .ram_add0      (ram_add0),
    .ram_add1      (ram_add1),
    .ram_data0_in  (ram_data0_in),
    .ram_data1_in  (ram_data1_in),
    .ram_data0_out (ram_data0_out),
    .ram_data1_out (ram_data1_out)
`ifdef DPRAM_ARB_INIT_EN
    ,
    .init_done     (init_done)
`endif
  );

  // Read-first RAM: registered outputs return the pre-write contents.
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (!ram_en) begin
      ram_data0_out <= '0;
      ram_data1_out <= '0;
    end else begin
      ram_data0_out <= mem[ram_add0];
      ram_data1_out <= mem[ram_add1];
      if (!ram_wr0) mem[ram_add0] <= ram_data0_in;
      if (!ram_wr1) mem[ram_add1] <= ram_data1_in;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [5:0] a, input logic [7:0] d);
    bus.req_valid[i]        = v;
    bus.req_wr[i]           = w;
    bus.req_addr[i*6 +: 6]  = a;
    bus.req_wdata[i*8 +: 8] = d;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_wr    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0]  exp_rv;
  logic [31:0] exp_rd;

  initial begin
    rst_n = 1'b0;
    idle();
    #12;
    check("rst_ready", bus.req_ready, 4'h0);
    check("rst_rsp_valid", bus.rsp_valid, 4'h0);
    check("rst_rsp_data", bus.rsp_data, 32'h0);
    check("rst_ram_en", ram_en, 1'b0);
    check("rst_wr0", ram_wr0, 1'b1);
    check("rst_wr1", ram_wr1, 1'b1);
    check("rst_add0", ram_add0, 6'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
`ifdef DPRAM_ARB_INIT_EN
    begin
      int waited;
      waited = 0;
      while (!init_done && waited < 100) begin
        step();
        waited++;
      end
      check("init_done_rise", init_done, 1'b1);
    end
`endif
    #1;
    check("run_ram_en", ram_en, 1'b1);

    // Requester 0 writes 0xA5 to addr 5, then reads it back.
    set_req(0, 1'b1, 1'b1, 6'd5, 8'hA5);
    #1;
    check("w5_ready", bus.req_ready, 4'b0001);
    check("w5_wr0", ram_wr0, 1'b0);
    check("w5_add0", ram_add0, 6'd5);
    check("w5_data0", ram_data0_in, 8'hA5);
    check("w5_wr1_idle", ram_wr1, 1'b1);
    step();
    set_req(0, 1'b1, 1'b0, 6'd5, 8'h00);
    #1;
    check("r5_ready", bus.req_ready, 4'b0001);
    check("r5_wr0", ram_wr0, 1'b1);
    check("w5_no_rsp", bus.rsp_valid, 4'b0000);
    step();
    idle();
    #1;
    check("r5_rsp_valid", bus.rsp_valid, 4'b0001);
    check("r5_rsp_data", bus.rsp_data, 32'h0000_00A5);

    // Requesters 1 and 2 write addrs 3 and 4 in the same cycle (ptr=1).
    set_req(1, 1'b1, 1'b1, 6'd3, 8'h11);
    set_req(2, 1'b1, 1'b1, 6'd4, 8'h22);
    #1;
    check("w34_ready", bus.req_ready, 4'b0110);
    check("w34_wr0", ram_wr0, 1'b0);
    check("w34_wr1", ram_wr1, 1'b0);
    check("w34_add1", ram_add1, 6'd4);
    check("w34_data1", ram_data1_in, 8'h22);
    step();
    set_req(1, 1'b1, 1'b0, 6'd3, 8'h00);
    set_req(2, 1'b1, 1'b0, 6'd4, 8'h00);
    #1;
    check("r34_ready", bus.req_ready, 4'b0110);
    step();
    idle();
    #1;
    check("r34_rsp_valid", bus.rsp_valid, 4'b0110);
    check("r34_rsp_data", bus.rsp_data, 32'h0022_1100);

    // Write collision on addr 9 (ptr=3): requester 0 wins, requester 1 retries.
    set_req(0, 1'b1, 1'b1, 6'd9, 8'h90);
    set_req(1, 1'b1, 1'b1, 6'd9, 8'h91);
    #1;
    check("col_ready", bus.req_ready, 4'b0001);
    check("col_wr1_idle", ram_wr1, 1'b1);
    step();
    set_req(0, 1'b0, 1'b0, 6'd0, 8'h00);
    #1;
    check("col_retry_ready", bus.req_ready, 4'b0010);
    check("col_retry_add0", ram_add0, 6'd9);
    check("col_retry_data0", ram_data0_in, 8'h91);
    step();
    idle();
    set_req(2, 1'b1, 1'b0, 6'd9, 8'h00);
    #1;
    check("r9_ready", bus.req_ready, 4'b0100);
    step();
    idle();
    #1;
    check("r9_rsp_valid", bus.rsp_valid, 4'b0100);
    check("r9_rsp_data", bus.rsp_data, 32'h0091_0000);

    // Same-cycle write and read of addr 7: read sees the old value (ptr=3).
    set_req(3, 1'b1, 1'b1, 6'd7, 8'h77);
    #1;
    check("w7_pre_ready", bus.req_ready, 4'b1000);
    step();
    idle();
    set_req(0, 1'b1, 1'b1, 6'd7, 8'h3C);
    set_req(1, 1'b1, 1'b0, 6'd7, 8'h00);
    #1;
    check("wr7_ready", bus.req_ready, 4'b0011);
    check("wr7_wr0", ram_wr0, 1'b0);
    check("wr7_wr1", ram_wr1, 1'b1);
    check("wr7_add1", ram_add1, 6'd7);
    step();
    idle();
    set_req(1, 1'b1, 1'b0, 6'd7, 8'h00);
    #1;
    check("wr7_old_valid", bus.rsp_valid, 4'b0010);
    check("wr7_old_data", bus.rsp_data, 32'h0000_7700);
    check("r7_ready", bus.req_ready, 4'b0010);
    step();
    idle();
    #1;
    check("r7_new_valid", bus.rsp_valid, 4'b0010);
    check("r7_new_data", bus.rsp_data, 32'h0000_3C00);

    // Bring the pointer back to 0 (ptr=2 -> requester 3 -> ptr=0).
    set_req(3, 1'b1, 1'b0, 6'd5, 8'h00);
    #1;
    check("p0_ready", bus.req_ready, 4'b1000);
    step();

    // All four read continuously: pairs (0,1),(2,3),...
    set_req(0, 1'b1, 1'b0, 6'd5, 8'h00);
    set_req(1, 1'b1, 1'b0, 6'd3, 8'h00);
    set_req(2, 1'b1, 1'b0, 6'd4, 8'h00);
    set_req(3, 1'b1, 1'b0, 6'd9, 8'h00);
    exp_rv = 4'b1000;
    exp_rd = 32'hA500_0000;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("all_ready_%0d", k), bus.req_ready, (k % 2 == 0) ? 4'b0011 : 4'b1100);
      check($sformatf("all_rv_%0d", k), bus.rsp_valid, exp_rv);
      check($sformatf("all_rd_%0d", k), bus.rsp_data, exp_rd);
      exp_rv = (k % 2 == 0) ? 4'b0011 : 4'b1100;
      exp_rd = (k % 2 == 0) ? 32'h0000_11A5 : 32'h9122_0000;
      step();
    end
    idle();
    #1;
    check("all_rv_last", bus.rsp_valid, exp_rv);
    check("all_rd_last", bus.rsp_data, exp_rd);

    // Reset with a read in flight: the response is dropped.
    set_req(2, 1'b1, 1'b0, 6'd4, 8'h00);
    #1;
    check("mid_ready", bus.req_ready, 4'b0100);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", bus.rsp_valid, 4'b0000);
    check("mid_rst_rsp_data", bus.rsp_data, 32'h0);
    check("mid_rst_ready", bus.req_ready, 4'b0000);
    check("mid_rst_wr0", ram_wr0, 1'b1);
    check("mid_rst_wr1", ram_wr1, 1'b1);
    check("mid_rst_ram_en", ram_en, 1'b0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    #1;
    check("post_rst_rsp_valid", bus.rsp_valid, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Shares the two ports of the 64x8 dual-port RAM (`dpram`) between N_REQ independent requesters.
- Each cycle: round-robin selects up to two requests, maps them onto RAM port 0/1, drives the RAM's active-low write strobes, and returns read data to the owning requester.
- Sits directly in front of `dpram`; requesters never touch the RAM pins.

Parameters:
- N_REQ, 4, number of requesters (legal 2..8)
- AW, 6, address width (64 words)
- DW, 8, data width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  request present, one bit per requester
- req_wr  in  N_REQ  1=write, 0=read (active-high at this interface)
- req_addr  in  N_REQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  N_REQ*DW  packed write data
- req_ready  out  N_REQ  request accepted this cycle
- rsp_valid  out  N_REQ  read data valid for requester i
- rsp_data  out  N_REQ*DW  packed read data
- ram_en  out  1  RAM enable (0 clears RAM outputs)
- ram_wr0, ram_wr1  out  1  RAM write strobes, active-low (0=write, 1=read)
- ram_add0, ram_add1  out  AW  RAM addresses
- ram_data0_in, ram_data1_in  out  DW  RAM write data
- ram_data0_out, ram_data1_out  in  DW  RAM registered read data

Behaviour:
- Reset (async, rst_n=0) clears all outputs to 0 except ram_wr0/ram_wr1, which reset to 1 (no write).
  - rr_ptr=0, response pipeline cleared, FSM to INIT (macro defined) or RUN.
  - A reset mid-operation drops in-flight responses; no rsp_valid is issued for them.
- FSM states: INIT, RUN.
  - INIT exists only with the optional feature.
  - RUN: ram_en=1 continuously.
- Grant (RUN, combinational from current inputs and rr_ptr):
  - Scan indices rr_ptr, rr_ptr+1, ... mod N_REQ.
  - First valid requester gets port 0; second valid requester gets port 1.
  - req_ready[i]=1 only for granted requesters; a transfer completes when valid&ready.
- Collision: if both grants are writes to the same address, the port-1 grant is withdrawn (ready=0, that requester retries).
  - Write+read to the same address in one cycle is allowed; the read returns the OLD data.
- RAM drive: granted write gives ram_wrX=0 plus addr/data. Granted read gives ram_wrX=1 plus addr. Idle port: ram_wrX=1, addr 0.
  - Idle reads are harmless; no response is generated for them.
- Pointer update on any grant: rr_ptr <= (highest-order granted index in scan order)+1 mod N_REQ. No grant: unchanged.
- Read latency: request accepted in cycle t → rsp_valid[i]=1 for exactly one cycle in t+1.
  - rsp_data slice i = ram_dataX_out of the port used.
  - A registered owner tag per port (valid, index) selects the slice.
  - Non-selected slices hold 0.
- Writes produce no response.
- A requester may hold valid continuously; back-to-back accepts give one response per accepted read, in order.
- Both ports granted to reads: two distinct requesters receive rsp_valid in the same cycle.

Optional Feature:
- Macro DPRAM_ARB_INIT_EN.
- Defined: after reset the FSM enters INIT and zero-fills the RAM.
  - Port 0 writes even addresses, port 1 odd addresses, one pair per cycle: 32 cycles, counter 0..31.
  - req_ready=0 throughout INIT; then RUN.
  - Output init_done is added (1 bit, 0 at reset, 1 from the first RUN cycle).
- Undefined: FSM resets directly to RUN, no init_done port, RAM contents undefined until written.

Decomposition:
- Package dpram_arb_pkg: AW/DW defaults, state enum {INIT, RUN}, owner-tag struct {valid, idx}.
- One natural sub-module: dpram_rr_pick2, combinational dual round-robin picker (valid vector + pointer → two one-hot grants).
- Collision check and response pipeline stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-read → rsp_valid=0, ram_wr0/1=1, req_ready=0 immediately. With INIT_EN, init_done rises 32 cycles after release.
- Requester 0 writes 0xA5 to addr 5, then reads addr 5 → ram_wr0=0 for one cycle; read response rsp_data[7:0]=0xA5 one cycle after accept.
- Requesters 1 and 2 write 0x11/0x22 to addrs 3/4 same cycle → both ready; subsequent reads return 0x11/0x22.
- Requesters 0 and 1 write addr 9 same cycle → only requester 0 ready; requester 1 accepted next cycle; final read returns requester 1's data.
- All four issue reads continuously from rr_ptr=0 → grant pairs (0,1),(2,3),(0,1)…; every requester gets a response every 2 cycles.
- Write 0x3C addr 7 by req 0 with read addr 7 by req 1 same cycle → response is old value; repeat read returns 0x3C.
